// File: rtl/axi4_lite_pkg.sv
// Shared definitions for AXI4-lite bus masters.
//   state_e    : transaction state of the single-outstanding initiator
//   req_t      : native request latched at accept time
//   PROT_*     : AxPROT encodings for data accesses and instruction fetches
//   AXI_*_W    : address, data and strobe widths of the AXI4-lite port
package axi4_lite_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [2:0] PROT_DATA = 3'b000;
  localparam logic [2:0] PROT_INSN = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_e;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  instr;
  } req_t;

endpackage

// File: rtl/axi_watchdog.sv
// Transaction watchdog for a bus master.
//   clk, resetn : clock, asynchronous active-low reset
//   clear       : restart the count (new transaction accepted)
//   run         : a transaction is in flight this cycle
//   timeout     : sticky flag, set once the in-flight count reaches
//                 TIMEOUT_CYCLES; cleared only by reset. 0 disables it.
module axi_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W          = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic timeout
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             timeout_q, timeout_d;

  // NOTE: every variable driven here gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d   = count_q;
    timeout_d = timeout_q;
    if (clear) begin
      count_d = '0;
    end else if (run && count_q != '1) begin
      // Saturate instead of wrapping so a hung bus cannot re-arm the compare.
      count_d = count_q + 1'b1;
    end
    // The flag rises on the same edge the count reaches the limit.
    if (TIMEOUT_CYCLES != 0 && !clear && run &&
        count_d == CNT_W'(TIMEOUT_CYCLES)) begin
      timeout_d = 1'b1;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the values from before the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/axi4_lite_initiator.sv
// Native valid/ready memory port to single-beat AXI4-lite initiator.
//   clk, resetn             : clock, asynchronous active-low reset
//   mem_valid/instr/addr/wdata/wstrb : native request (wstrb==0 is a read)
//   mem_ready, mem_rdata    : one-cycle completion pulse and read data
//   timeout                 : sticky watchdog flag
//   mem_axi_aw*/w*/b*       : AXI4-lite write address, data, response
//   mem_axi_ar*/r*          : AXI4-lite read address and data
// One transaction is outstanding at a time; all outputs come from flops.
module axi4_lite_initiator
  import axi4_lite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_valid,
  input  logic                  mem_instr,
  input  logic [AXI_ADDR_W-1:0] mem_addr,
  input  logic [AXI_DATA_W-1:0] mem_wdata,
  input  logic [AXI_STRB_W-1:0] mem_wstrb,
  output logic                  mem_ready,
  output logic [AXI_DATA_W-1:0] mem_rdata,
  output logic                  timeout,
  output logic                  mem_axi_awvalid,
  input  logic                  mem_axi_awready,
  output logic [AXI_ADDR_W-1:0] mem_axi_awaddr,
  output logic [2:0]            mem_axi_awprot,
  output logic                  mem_axi_wvalid,
  input  logic                  mem_axi_wready,
  output logic [AXI_DATA_W-1:0] mem_axi_wdata,
  output logic [AXI_STRB_W-1:0] mem_axi_wstrb,
  input  logic                  mem_axi_bvalid,
  output logic                  mem_axi_bready,
  output logic                  mem_axi_arvalid,
  input  logic                  mem_axi_arready,
  output logic [AXI_ADDR_W-1:0] mem_axi_araddr,
  output logic [2:0]            mem_axi_arprot,
  input  logic                  mem_axi_rvalid,
  output logic                  mem_axi_rready,
  input  logic [AXI_DATA_W-1:0] mem_axi_rdata
);

  state_e                state_q, state_d;
  req_t                  req_q, req_d;
  logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  mem_ready_q, mem_ready_d;
  logic                  accept;
  logic                  run;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    accept    = 1'b0;

    case (state_q)
      IDLE: begin
        // mem_valid is looked at only here, so a request still held during
        // the DONE cycle is never issued twice.
        if (mem_valid) begin
          accept    = 1'b1;
          req_d     = '{addr: mem_addr, wdata: mem_wdata,
                        wstrb: mem_wstrb, instr: mem_instr};
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (|mem_wstrb) ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: if (arvalid_q && mem_axi_arready) state_d = RD_DATA;
      RD_DATA: begin
        if (mem_axi_rvalid) begin
          rdata_d = mem_axi_rdata;
          state_d = DONE;
        end
      end
      WR_REQ: begin
        // AW and W complete independently, in either order or together.
        aw_done_d = aw_done_q | (awvalid_q & mem_axi_awready);
        w_done_d  = w_done_q  | (wvalid_q  & mem_axi_wready);
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: if (mem_axi_bvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Handshake outputs are decoded from the next state and registered, so
    // no input reaches an output combinationally.
    arvalid_d   = (state_d == RD_ADDR);
    rready_d    = (state_d == RD_DATA);
    awvalid_d   = (state_d == WR_REQ) && !aw_done_d;
    wvalid_d    = (state_d == WR_REQ) && !w_done_d;
    bready_d    = (state_d == WR_RESP);
    mem_ready_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      req_q       <= '0;
      rdata_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rdata_q     <= rdata_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  assign run = (state_q != IDLE) && (state_q != DONE);

  axi_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .resetn (resetn),
    .clear  (accept),
    .run    (run),
    .timeout(timeout)
  );

  assign mem_ready       = mem_ready_q;
  assign mem_rdata       = rdata_q;
  assign mem_axi_awvalid = awvalid_q;
  assign mem_axi_awaddr  = req_q.addr;
  assign mem_axi_awprot  = PROT_DATA;
  assign mem_axi_wvalid  = wvalid_q;
  assign mem_axi_wdata   = req_q.wdata;
  assign mem_axi_wstrb   = req_q.wstrb;
  assign mem_axi_bready  = bready_q;
  assign mem_axi_arvalid = arvalid_q;
  assign mem_axi_araddr  = req_q.addr;
  assign mem_axi_arprot  = req_q.instr ? PROT_INSN : PROT_DATA;
  assign mem_axi_rready  = rready_q;

endmodule
